// File: rtl/shmem_port_adapter.sv
// Request front-end for one port of dual_port_ram: valid/ready commands in, raw RAM port out, read data into a response FIFO.
// Latency: RAM drive is combinational; a read's response is visible RD_LATENCY+1 cycles after its command handshake.
// Backpressure: credit based; cmd_ready deasserts once queued plus in-flight reads reach RSP_DEPTH, so the FIFO never overflows.
module shmem_port_adapter #(
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int RD_LATENCY       = 1,
    parameter int RSP_DEPTH        = 2,
    parameter int STAT_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [LOCAL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]       cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        ram_we,
    output logic [LOCAL_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata,
    output logic [STAT_WIDTH-1:0]       wr_count,
    output logic [STAT_WIDTH-1:0]       rd_count
);

    // Pointer, count and credit widths; outstanding can briefly count FIFO plus a full pipe.
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = $clog2(RSP_DEPTH + RD_LATENCY + 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [STAT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [STAT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [OW-1:0]         outstanding;

    logic accept, wr_acc, rd_acc, push, pop;

    assign accept = cmd_valid & cmd_ready;
    assign wr_acc = accept & cmd_we;
    assign rd_acc = accept & ~cmd_we;

    // The read whose bit leaves the last stage has its data on ram_rdata this cycle.
    assign push = rd_pipe_q[RD_LATENCY-1];
    assign pop  = rsp_valid & rsp_ready;

    // Raw RAM port: address/data always pass through, we only on an accepted write.
    assign ram_addr  = cmd_addr;
    assign ram_wdata = cmd_wdata;
    assign ram_we    = wr_acc;

    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = fifo_mem_q[rd_ptr_q];
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;

    // Credits from registered state only: queued responses plus reads still in the RAM pipe.
    always_comb begin
        outstanding = OW'(cnt_q);
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding = outstanding + OW'(rd_pipe_q[i]);
        end
    end

    assign cmd_ready = ~rst & (outstanding < OW'(RSP_DEPTH));

    // Next state for the read pipe, FIFO pointers/count and saturating statistics.
    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = rd_acc;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        // Explicit wrap so non-power-of-two depths work.
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        wr_count_d = wr_count_q;
        if (wr_acc && (wr_count_q != STAT_MAX)) begin
            wr_count_d = wr_count_q + STAT_WIDTH'(1);
        end
        rd_count_d = rd_count_q;
        if (rd_acc && (rd_count_q != STAT_MAX)) begin
            rd_count_d = rd_count_q + STAT_WIDTH'(1);
        end
    end

    // Control state; reset drops in-flight reads and queued responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            rd_pipe_q  <= rd_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Response storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_rdata;
        end
    end

    // Credit gating makes a push into a full FIFO impossible; catch it if it ever happens.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (cnt_q == CW'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_shmem_port_adapter.sv
module tb_shmem_port_adapter;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [15:0] wr_count, rd_count;

    // Second instance with 4-bit statistics for the saturation check.
    logic        s_cmd_valid, s_cmd_ready, s_cmd_we;
    logic [9:0]  s_cmd_addr;
    logic [31:0] s_cmd_wdata;
    logic        s_rsp_valid, s_rsp_ready;
    logic [31:0] s_rsp_data;
    logic        s_ram_we;
    logic [9:0]  s_ram_addr;
    logic [31:0] s_ram_wdata;
    logic [3:0]  s_wr_count, s_rd_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];

    shmem_port_adapter dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    shmem_port_adapter #(.STAT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_we(s_cmd_we),
        .cmd_addr(s_cmd_addr), .cmd_wdata(s_cmd_wdata),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(32'h0),
        .wr_count(s_wr_count), .rd_count(s_rd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM, one-cycle read latency, write-first.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= ram_wdata;
        end else begin
            ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic        held_vld;
        int          sent, got, cyc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'd1;
        mem[10'h011] = 32'd2;
        mem[10'h012] = 32'd3;
        for (int i = 0; i < 20; i++) mem[10'h100 + i] = 32'hC0DE0000 + 32'(i);

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_we = 1'b0; s_cmd_addr = '0; s_cmd_wdata = '0; s_rsp_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_wr_count",  32'(wr_count),  32'd0);
        chk("rst_rd_count",  32'(rd_count),  32'd0);
        tick; tick;
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0x03F then read it back
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h03F; cmd_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_ram_we_on",   32'(ram_we),   32'd1);
        chk("t1_ram_addr",    32'(ram_addr), 32'h03F);
        chk("t1_ram_wdata",   ram_wdata,     32'hDEADBEEF);
        tick;
        cmd_we = 1'b0; cmd_wdata = 32'h0;
        #1;
        chk("t1_ram_we_read", 32'(ram_we),   32'd0);
        chk("t1_wr_count",    32'(wr_count), 32'd1);
        chk("t1_rd_ready",    32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
        #1;
        chk("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
        chk("t1_rd_count",    32'(rd_count),  32'd1);
        tick;
        chk("t1_rsp_valid",   32'(rsp_valid), 32'd1);
        chk("t1_rsp_data",    rsp_data,       32'hDEADBEEF);
        tick;
        chk("t1_rsp_popped",  32'(rsp_valid), 32'd0);

        // Back-to-back reads against a stalled consumer
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010;
        #1;
        chk("t2_ready0", 32'(cmd_ready), 32'd1);
        tick;
        cmd_addr = 10'h011;
        #1;
        chk("t2_ready1", 32'(cmd_ready), 32'd1);
        tick;
        cmd_addr = 10'h012;
        #1;
        chk("t2_ready_drop", 32'(cmd_ready), 32'd0);
        tick;
        chk("t2_still_full", 32'(cmd_ready), 32'd0);
        chk("t2_head_vld",   32'(rsp_valid), 32'd1);
        chk("t2_head_1",     rsp_data,       32'd1);
        tick;
        chk("t2_stall_hold", rsp_data,       32'd1);
        rsp_ready = 1'b1;
        tick;
        chk("t2_data_2",      rsp_data,       32'd2);
        chk("t2_credit_back", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
        #1;
        chk("t2_drained", 32'(rsp_valid), 32'd0);
        tick;
        chk("t2_vld_3",  32'(rsp_valid), 32'd1);
        chk("t2_data_3", rsp_data,       32'd3);
        tick;
        chk("t2_empty", 32'(rsp_valid), 32'd0);

        // Write immediately followed by read of the same address
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h040; cmd_wdata = 32'hA5A50001;
        tick;
        cmd_we = 1'b0; cmd_wdata = 32'h0;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("t3_vld",  32'(rsp_valid), 32'd1);
        chk("t3_data", rsp_data,       32'hA5A50001);
        tick;

        // Streaming reads with toggling rsp_ready
        sent = 0; got = 0; cyc = 0; held_vld = 1'b0; held = '0;
        while (got < 20 && cyc < 300) begin
            cmd_valid = (sent < 20);
            cmd_we    = 1'b0;
            cmd_addr  = 10'h100 + 10'(sent);
            rsp_ready = cyc[0];
            #1;
            if (held_vld) chk("t4_stall_stable", rsp_data, held);
            held_vld = 1'b0;
            if (rsp_valid && rsp_ready) begin
                chk("t4_order_data", rsp_data, 32'hC0DE0000 + 32'(got));
                got++;
            end else if (rsp_valid) begin
                held     = rsp_data;
                held_vld = 1'b1;
            end
            if (cmd_valid && cmd_ready) sent++;
            tick;
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("t4_all_received", 32'(got), 32'd20);
        tick; tick; tick;
        chk("t4_no_extra", 32'(rsp_valid), 32'd0);
        chk("t4_wr_count", 32'(wr_count),  32'd2);
        chk("t4_rd_count", 32'(rd_count),  32'd25);

        // Reset with one response queued and one read in flight
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010;
        tick;
        cmd_addr = 10'h011;
        tick;
        cmd_valid = 1'b0;
        #1;
        chk("t5_pre_vld", 32'(rsp_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_async_vld",   32'(rsp_valid), 32'd0);
        chk("t5_async_ready", 32'(cmd_ready), 32'd0);
        chk("t5_async_wr",    32'(wr_count),  32'd0);
        chk("t5_async_rd",    32'(rd_count),  32'd0);
        rsp_ready = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t5_rel_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t5_no_stale", 32'(rsp_valid), 32'd0);
        end

        // Saturating write counter with 4-bit statistics
        s_cmd_valid = 1'b1; s_cmd_we = 1'b1; s_cmd_addr = 10'h2AA; s_cmd_wdata = 32'h1234;
        #1;
        chk("t6_ram_we",    32'(s_ram_we),    32'd1);
        chk("t6_ram_addr",  32'(s_ram_addr),  32'h2AA);
        chk("t6_ram_wdata", s_ram_wdata,      32'h1234);
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 14) chk("t6_wr_14", 32'(s_wr_count), 32'd14);
            if (i == 15) chk("t6_wr_15", 32'(s_wr_count), 32'd15);
        end
        s_cmd_valid = 1'b0;
        #1;
        chk("t6_wr_sat",  32'(s_wr_count),  32'd15);
        chk("t6_rd_zero", 32'(s_rd_count),  32'd0);
        chk("t6_no_rsp",  32'(s_rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
